// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU control decode and execute stage with
// iterative unsigned multu/divu into internal HI/LO registers.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       ctrl,
    output logic             illegal,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_NOR  = 4'b1100;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_MUL  = 4'b1000;
    localparam logic [3:0] C_DIV  = 4'b1001;
    localparam logic [3:0] C_MFHI = 4'b1010;
    localparam logic [3:0] C_MFLO = 4'b1011;
    localparam logic [3:0] C_ILL  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] wa;
    logic [WIDTH-1:0] wb;
    logic [WIDTH-1:0] wd;
    logic [3:0]       dctrl;
    logic             dill;
    logic [WIDTH-1:0] sres;
    logic             accept;
    logic             start_mul;
    logic             start_div;
    logic             last;
    logic [WIDTH:0]   msum;
    logic             dge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign zero      = (result == '0);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && !dill && (dctrl == C_MUL);
    assign start_div = accept && !dill && (dctrl == C_DIV) && (b != '0);
    assign last      = (cnt == CW'(1));

    always_comb begin
        dctrl = C_ILL;
        dill  = 1'b1;
        unique case (alu_op)
            2'b00: begin dctrl = C_ADD; dill = 1'b0; end
            2'b01: begin dctrl = C_SUB; dill = 1'b0; end
            2'b10: begin
                dill = 1'b0;
                case (funct)
                    6'b100000: dctrl = C_ADD;
                    6'b100010: dctrl = C_SUB;
                    6'b100100: dctrl = C_AND;
                    6'b100101: dctrl = C_OR;
                    6'b100111: dctrl = C_NOR;
                    6'b101010: dctrl = C_SLT;
                    6'b011001: dctrl = C_MUL;
                    6'b011011: dctrl = C_DIV;
                    6'b010000: dctrl = C_MFHI;
                    6'b010010: dctrl = C_MFLO;
                    default:   dill  = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // C_DIV only reaches this path when b == 0
    always_comb begin
        sres = '0;
        case (dctrl)
            C_ADD:  sres = a + b;
            C_SUB:  sres = a - b;
            C_AND:  sres = a & b;
            C_OR:   sres = a | b;
            C_NOR:  sres = ~(a | b);
            C_SLT:  sres = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            C_DIV:  sres = '1;
            C_MFHI: sres = hi;
            C_MFLO: sres = lo;
            default: sres = '0;
        endcase
    end

    // wa/wb hold {hi,lo} partials (mul) or {rem,quo} (div); wd the operand
    always_comb begin
        msum    = {1'b0, wa} + (wb[0] ? {1'b0, wd} : '0);
        dge     = ({wa, wb[WIDTH-1]} >= {1'b0, wd});
        step_hi = {wa[WIDTH-2:0], wb[WIDTH-1]};
        if (dge)
            step_hi = {wa[WIDTH-2:0], wb[WIDTH-1]} - wd;
        step_lo = {wb[WIDTH-2:0], dge};
        if (state == S_MUL) begin
            step_hi = msum[WIDTH:1];
            step_lo = {msum[0], wb[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start_mul)
                    state_nx = S_MUL;
                else if (start_div)
                    state_nx = S_DIV;
            end
            S_MUL, S_DIV: if (last) state_nx = S_DONE;
            S_DONE:       state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            wa        <= '0;
            wb        <= '0;
            wd        <= '0;
            result    <= '0;
            ctrl      <= '0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= 1'b0;
            if (accept) begin
                cnt <= CW'(WIDTH);
                wa  <= '0;
                wb  <= start_mul ? b : a;
                wd  <= start_mul ? a : b;
                if (!start_mul && !start_div) begin
                    out_valid <= 1'b1;
                    result    <= sres;
                    ctrl      <= dctrl;
                    illegal   <= dill;
                    if (!dill && dctrl == C_DIV) begin
                        hi <= a;
                        lo <= '1;
                    end
                end
            end else if (state == S_MUL || state == S_DIV) begin
                cnt <= cnt - 1'b1;
                wa  <= step_hi;
                wb  <= step_lo;
                if (last) begin
                    hi        <= step_hi;
                    lo        <= step_lo;
                    result    <= step_lo;
                    ctrl      <= (state == S_MUL) ? C_MUL : C_DIV;
                    illegal   <= 1'b0;
                    out_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench with a plain-arithmetic
// reference model and randomized plus directed stimulus.
module tb_alu_exec_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [1:0]   alu_op = '0;
    logic [5:0]   funct = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic [3:0]   ctrl;
    logic         illegal;
    logic         busy;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   ctrl;
        logic         ill;
        int           when;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int           checks = 0;
    int           passes = 0;
    int           cyc = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;
    logic [5:0]   flist[10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27,
                                6'h2A, 6'h19, 6'h1B, 6'h10, 6'h12};

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .alu_op(alu_op),
        .funct(funct),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .result(result),
        .zero(zero),
        .ctrl(ctrl),
        .illegal(illegal),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] req);
        checks++;
        if (act === req)
            passes++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     name, act, req, cyc);
    endfunction

    // Reference: MIPS semantics with HI/LO kept as plain variables
    function automatic exp_t model(logic [1:0] op, logic [5:0] f,
                                   logic [W-1:0] x, logic [W-1:0] y);
        exp_t         e;
        logic [2*W-1:0] p;
        e.res  = '0;
        e.ctrl = 4'hF;
        e.ill  = 1'b1;
        e.when = 0;
        if (op == 2'b00) begin
            e.res = x + y; e.ctrl = 4'h2; e.ill = 1'b0;
        end else if (op == 2'b01) begin
            e.res = x - y; e.ctrl = 4'h6; e.ill = 1'b0;
        end else if (op == 2'b10) begin
            e.ill = 1'b0;
            case (f)
                6'h20: begin e.res = x + y; e.ctrl = 4'h2; end
                6'h22: begin e.res = x - y; e.ctrl = 4'h6; end
                6'h24: begin e.res = x & y; e.ctrl = 4'h0; end
                6'h25: begin e.res = x | y; e.ctrl = 4'h1; end
                6'h27: begin e.res = ~(x | y); e.ctrl = 4'hC; end
                6'h2A: begin
                    e.res  = (int'(x) < int'(y)) ? 1 : 0;
                    e.ctrl = 4'h7;
                end
                6'h19: begin
                    p      = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                    mhi    = p[2*W-1:W];
                    mlo    = p[W-1:0];
                    e.res  = mlo;
                    e.ctrl = 4'h8;
                    e.when = W;
                end
                6'h1B: begin
                    if (y == 0) begin
                        mlo = '1;
                        mhi = x;
                    end else begin
                        mlo    = x / y;
                        mhi    = x % y;
                        e.when = W;
                    end
                    e.res  = mlo;
                    e.ctrl = 4'h9;
                end
                6'h10: begin e.res = mhi; e.ctrl = 4'hA; end
                6'h12: begin e.res = mlo; e.ctrl = 4'hB; end
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         output int waits);
        exp_t e;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        alu_op   = op;
        funct    = f;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
        e = model(op, f, x, y);
        e.when += cyc;
        sb.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic iss(input logic [1:0] op, input logic [5:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y);
        int w;
        issue(op, f, x, y, w);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("ctrl", ctrl, mon_e.ctrl);
                chk("illegal", illegal, mon_e.ill);
                chk("zero", zero, mon_e.res == 0);
                chk("completion_cycle", cyc, mon_e.when);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_result", result, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_zero", zero, 1);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;

        iss(2'b00, 6'h00, 32'h7FFF_FFFF, 32'h1);
        iss(2'b01, 6'h00, 32'd5, 32'd5);
        iss(2'b10, 6'h24, 32'hF0F0, 32'h0FF0);
        iss(2'b10, 6'h25, 32'hF0F0, 32'h0FF0);
        iss(2'b10, 6'h27, 32'hF0F0, 32'h0FF0);
        iss(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'h1);

        iss(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("busy_after_multu", busy, 1);
        chk("ready_after_multu", in_ready, 0);
        issue(2'b10, 6'h10, 32'h0, 32'h0, w);
        chk("multu_ready_low_cycles", w, 33);

        iss(2'b10, 6'h1B, 32'd100, 32'd7);
        issue(2'b10, 6'h10, 32'h0, 32'h0, w);
        chk("divu_ready_low_cycles", w, 33);
        iss(2'b10, 6'h12, 32'h0, 32'h0);
        iss(2'b10, 6'h1B, 32'd9, 32'd0);
        iss(2'b10, 6'h10, 32'h0, 32'h0);
        iss(2'b11, 6'h20, 32'h1234, 32'h5678);
        iss(2'b10, 6'h00, 32'h1234, 32'h5678);
        iss(2'b10, 6'h10, 32'h0, 32'h0);
        drain();

        for (int i = 0; i < 150; i++) begin
            logic [1:0]   op;
            logic [5:0]   f;
            logic [W-1:0] x;
            logic [W-1:0] y;
            int           k;
            k  = $urandom_range(0, 9);
            op = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 :
                 (k == 2) ? 2'b11 : 2'b10;
            k  = $urandom_range(0, 11);
            f  = (k < 10) ? flist[k] : 6'($urandom);
            x  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                             : $urandom;
            k  = $urandom_range(0, 7);
            y  = (k == 0) ? '0 : (k == 1) ? $urandom_range(1, 15)
                                          : $urandom;
            iss(op, f, x, y);
        end
        drain();

        iss(2'b10, 6'h19, $urandom, $urandom);
        repeat (10) @(negedge clk);
        sb.delete();
        mhi   = '0;
        mlo   = '0;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        iss(2'b10, 6'h12, 32'h0, 32'h0);
        iss(2'b10, 6'h10, 32'h0, 32'h0);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
